// File: rtl/lif_step_seq.sv
// One leaky-integrate-and-fire membrane update per accepted step, sequenced
// through an external combinational float ALU (MUL, ADD, CMP), one result per step.
module lif_step_seq #(
  parameter int REFRAC_STEPS = 2,
  parameter int CNT_W        = 4   // REFRAC_STEPS must fit: REFRAC_STEPS < 2**CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        v_load,
  input  logic [31:0] v_load_val,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] i_in,
  input  logic [31:0] leak,
  input  logic [31:0] thr,
  input  logic [31:0] v_reset,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] v_out,
  output logic        spike,
  output logic        nan_err,
  output logic [1:0]  falu_opf,
  output logic [31:0] falu_regb,
  output logic [31:0] falu_regc,
  input  logic [31:0] falu_rega
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_ADD  = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]      v_reg;
  logic [31:0]      p_reg;
  logic [31:0]      s_reg;
  logic [31:0]      d_reg;
  logic [31:0]      i_in_reg;
  logic [31:0]      leak_reg;
  logic [31:0]      thr_reg;
  logic [31:0]      v_reset_reg;
  logic [CNT_W-1:0] refrac_cnt_reg;
  logic             out_valid_reg;
  logic [31:0]      v_out_reg;
  logic             spike_reg;
  logic             nan_err_reg;

  logic accept;
  logic any_nan;
  logic fire;

  assign in_ready = (state_reg == ST_IDLE) && !out_valid_reg && !v_load;
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_reg;
  assign v_out     = v_out_reg;
  assign spike     = spike_reg;
  assign nan_err   = nan_err_reg;

  // NaN flags for the three intermediate ALU results of the step
  logic [31:0] chk_val [3];
  logic [2:0]  nan_vec;

  assign chk_val[0] = p_reg;
  assign chk_val[1] = s_reg;
  assign chk_val[2] = d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_nan
      assign nan_vec[gi] = (chk_val[gi][30:23] == 8'hFF) && (chk_val[gi][22:0] != 23'd0);
    end
  endgenerate

  assign any_nan = |nan_vec;
  // s - thr >= 0 also holds for -0.0, hence the magnitude-zero term
  assign fire    = !nan_vec[2] && (!d_reg[31] || (d_reg[30:0] == 31'd0));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_MUL;
      ST_MUL:  state_next = ST_ADD;
      ST_ADD:  state_next = ST_CMP;
      ST_CMP:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ALU operand drive
  always_comb begin
    falu_opf  = OP_ADD;
    falu_regb = 32'd0;
    falu_regc = 32'd0;
    case (state_reg)
      ST_MUL: begin
        falu_opf  = OP_MUL;
        falu_regb = v_reg;
        falu_regc = leak_reg;
      end
      ST_ADD: begin
        falu_opf  = OP_ADD;
        falu_regb = p_reg;
        falu_regc = i_in_reg;
      end
      ST_CMP: begin
        falu_opf  = OP_SUB;
        falu_regb = s_reg;
        falu_regc = thr_reg;
      end
      default: begin
        falu_opf  = OP_ADD;
        falu_regb = 32'd0;
        falu_regc = 32'd0;
      end
    endcase
  end

  // Operand capture, intermediate results, membrane state and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_reg          <= 32'd0;
      p_reg          <= 32'd0;
      s_reg          <= 32'd0;
      d_reg          <= 32'd0;
      i_in_reg       <= 32'd0;
      leak_reg       <= 32'd0;
      thr_reg        <= 32'd0;
      v_reset_reg    <= 32'd0;
      refrac_cnt_reg <= '0;
      out_valid_reg  <= 1'b0;
      v_out_reg      <= 32'd0;
      spike_reg      <= 1'b0;
      nan_err_reg    <= 1'b0;
    end else begin
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (v_load) begin
            v_reg          <= v_load_val;
            refrac_cnt_reg <= '0;
          end else if (accept) begin
            i_in_reg    <= i_in;
            leak_reg    <= leak;
            thr_reg     <= thr;
            v_reset_reg <= v_reset;
          end
        end
        ST_MUL: p_reg <= falu_rega;
        ST_ADD: s_reg <= falu_rega;
        ST_CMP: d_reg <= falu_rega;
        ST_DONE: begin
          out_valid_reg <= 1'b1;
          if (refrac_cnt_reg != '0) begin
            // Refractory: arithmetic results are discarded
            v_reg          <= v_reset_reg;
            v_out_reg      <= v_reset_reg;
            spike_reg      <= 1'b0;
            nan_err_reg    <= 1'b0;
            refrac_cnt_reg <= refrac_cnt_reg - CNT_W'(1);
          end else if (any_nan) begin
            v_reg       <= s_reg;
            v_out_reg   <= s_reg;
            spike_reg   <= 1'b0;
            nan_err_reg <= 1'b1;
          end else if (fire) begin
            v_reg          <= v_reset_reg;
            v_out_reg      <= v_reset_reg;
            spike_reg      <= 1'b1;
            nan_err_reg    <= 1'b0;
            refrac_cnt_reg <= CNT_W'(REFRAC_STEPS);
          end else begin
            v_reg       <= s_reg;
            v_out_reg   <= s_reg;
            spike_reg   <= 1'b0;
            nan_err_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_step_seq.sv
// Directed bench for lif_step_seq with a table-driven float ALU covering the
// exact operand pairs the directed vectors produce.
module tb_lif_step_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_load;
  logic [31:0] v_load_val;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] i_in, leak, thr, v_reset;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] v_out;
  logic        spike;
  logic        nan_err;
  logic [1:0]  falu_opf;
  logic [31:0] falu_regb, falu_regc, falu_rega;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] F_0    = 32'h00000000;
  localparam logic [31:0] F_HALF = 32'h3F000000;
  localparam logic [31:0] F_1    = 32'h3F800000;
  localparam logic [31:0] F_1P5  = 32'h3FC00000;
  localparam logic [31:0] F_2    = 32'h40000000;
  localparam logic [31:0] F_3    = 32'h40400000;
  localparam logic [31:0] F_QNAN = 32'h7FC00000;

  always #5 clk = ~clk;

  lif_step_seq #(.REFRAC_STEPS(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .v_load(v_load), .v_load_val(v_load_val),
    .in_valid(in_valid), .in_ready(in_ready), .i_in(i_in), .leak(leak),
    .thr(thr), .v_reset(v_reset), .out_valid(out_valid), .out_ready(out_ready),
    .v_out(v_out), .spike(spike), .nan_err(nan_err), .falu_opf(falu_opf),
    .falu_regb(falu_regb), .falu_regc(falu_regc), .falu_rega(falu_rega)
  );

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Hand-computed float results for the operand pairs used below
  function automatic logic [31:0] alu_model(input logic [1:0] op, input logic [31:0] b, input logic [31:0] c);
    if (is_nan(b) || is_nan(c)) return F_QNAN;
    case (op)
      2'b00: begin
        if (b == F_0) return c;
        if (b == 32'h3F400000 && c == F_1P5) return 32'h40100000;
        if (b == F_1 && c == F_1) return F_2;
      end
      2'b01: begin
        if (b == c) return F_0;
        if (b == F_1P5 && c == F_2) return 32'hBF000000;
        if (b == 32'h40100000 && c == F_2) return 32'h3E800000;
      end
      2'b10: begin
        if (b == F_0 || c == F_0) return F_0;
        if (c == F_1) return b;
        if (b == F_1P5 && c == F_HALF) return 32'h3F400000;
      end
      default: ;
    endcase
    return 32'hDEADBEEF;
  endfunction

  always_comb falu_rega = alu_model(falu_opf, falu_regb, falu_regc);

  task automatic load_v(input logic [31:0] val);
    @(negedge clk);
    v_load = 1'b1;
    v_load_val = val;
    @(negedge clk);
    v_load = 1'b0;
  endtask

  // Runs one step with an immediate handshake; returns result and accept-to-valid edge count
  task automatic run_step(input logic [31:0] ii, input logic [31:0] lk, input logic [31:0] th,
                          input logic [31:0] vr, output logic [31:0] vo, output logic sp,
                          output logic ne, output int lat);
    int n;
    @(negedge clk);
    i_in = ii; leak = lk; thr = th; v_reset = vr;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (n >= 20) lat = 99;
    vo = v_out; sp = spike; ne = nan_err;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    int seen;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || v_out !== 32'd0 || spike !== 1'b0 || nan_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ov=%b v_out=%h spike=%b nan=%b want 0 0 0 0", out_valid, v_out, spike, nan_err);
    end
    checks++;
    if (falu_opf !== 2'b00 || falu_regb !== 32'd0 || falu_regc !== 32'd0) begin
      errors++;
      $display("FAIL reset_alu got opf=%b b=%h c=%h want 00 0 0", falu_opf, falu_regb, falu_regc);
    end
    rst_n = 1'b1;
    load_v(F_1);
    // Start a step, then abort it with reset during MUL
    @(negedge clk);
    i_in = F_1P5; leak = F_HALF; thr = F_2; v_reset = F_0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (falu_opf !== 2'b10 || falu_regb !== F_1 || falu_regc !== F_HALF) begin
      errors++;
      $display("FAIL mul_operands got opf=%b b=%h c=%h want 10 %h %h", falu_opf, falu_regb, falu_regc, F_1, F_HALF);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort got valid_cycles=%0d in_ready=%b want 0 1", seen, in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_integrate;
    logic [31:0] vo; logic sp, ne; int lat;
    run_step(F_1P5, F_HALF, F_2, F_0, vo, sp, ne, lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL integrate_latency got %0d want 4", lat);
    end
    checks++;
    if (vo !== F_1P5 || sp !== 1'b0 || ne !== 1'b0) begin
      errors++;
      $display("FAIL integrate_result got v=%h spike=%b nan=%b want %h 0 0", vo, sp, ne, F_1P5);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL integrate_handshake got out_valid=%b want 0", out_valid);
    end
    $display("test_integrate v_out=%h spike=%b lat=%0d", vo, sp, lat);
  endtask

  task automatic test_fire;
    logic [31:0] vo; logic sp, ne; int lat;
    run_step(F_1P5, F_HALF, F_2, F_0, vo, sp, ne, lat);
    checks++;
    if (vo !== F_0 || sp !== 1'b1 || ne !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL fire got v=%h spike=%b nan=%b lat=%0d want %h 1 0 4", vo, sp, ne, lat, F_0);
    end
    $display("test_fire v_out=%h spike=%b", vo, sp);
  endtask

  task automatic test_refractory;
    logic [31:0] vo; logic sp, ne; int lat;
    for (int k = 0; k < 2; k++) begin
      run_step(F_1P5, F_HALF, F_2, F_0, vo, sp, ne, lat);
      checks++;
      if (vo !== F_0 || sp !== 1'b0 || ne !== 1'b0 || lat != 4) begin
        errors++;
        $display("FAIL refrac_%0d got v=%h spike=%b nan=%b lat=%0d want %h 0 0 4", k, vo, sp, ne, lat, F_0);
      end
      $display("test_refractory step %0d v_out=%h spike=%b", k, vo, sp);
    end
    run_step(F_1P5, F_HALF, F_2, F_0, vo, sp, ne, lat);
    checks++;
    if (vo !== F_1P5 || sp !== 1'b0 || ne !== 1'b0) begin
      errors++;
      $display("FAIL refrac_exit got v=%h spike=%b nan=%b want %h 0 0", vo, sp, ne, F_1P5);
    end
    $display("test_refractory exit v_out=%h spike=%b", vo, sp);
  endtask

  task automatic test_equality_nan;
    logic [31:0] vo; logic sp, ne; int lat;
    @(negedge clk);
    v_load = 1'b1;
    v_load_val = F_1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL vload_blocks_ready got in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    v_load = 1'b0;
    run_step(F_1, F_1, F_2, F_0, vo, sp, ne, lat);
    checks++;
    if (vo !== F_0 || sp !== 1'b1 || ne !== 1'b0) begin
      errors++;
      $display("FAIL equality got v=%h spike=%b nan=%b want %h 1 0", vo, sp, ne, F_0);
    end
    $display("test_equality v_out=%h spike=%b", vo, sp);
    load_v(F_1);
    run_step(F_QNAN, F_1, F_2, F_0, vo, sp, ne, lat);
    checks++;
    if (vo !== F_QNAN || sp !== 1'b0 || ne !== 1'b1) begin
      errors++;
      $display("FAIL nan got v=%h spike=%b nan=%b want %h 0 1", vo, sp, ne, F_QNAN);
    end
    $display("test_nan v_out=%h nan_err=%b", vo, ne);
  endtask

  task automatic test_backpressure;
    logic [31:0] vo; logic sp, ne; int lat, n, bad;
    load_v(F_0);
    @(negedge clk);
    i_in = F_1P5; leak = F_HALF; thr = F_2; v_reset = F_0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // v_load held high across MUL..DONE must not touch v
    v_load = 1'b1;
    v_load_val = F_3;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got in_ready=%b want 0", in_ready);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    v_load = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL bp_latency got %0d want 4", n);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || v_out !== F_1P5 || spike !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got unstable_cycles=%0d v_out=%h want 0 %h", bad, v_out, F_1P5);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got out_valid=%b want 0", out_valid);
    end
    run_step(F_1P5, F_HALF, F_2, F_0, vo, sp, ne, lat);
    checks++;
    if (vo !== F_0 || sp !== 1'b1) begin
      errors++;
      $display("FAIL vload_ignored got v=%h spike=%b want %h 1", vo, sp, F_0);
    end
    $display("test_backpressure held=10 next v_out=%h spike=%b", vo, sp);
  endtask

  initial begin
    rst_n = 1'b0; v_load = 1'b0; v_load_val = 32'd0; in_valid = 1'b0;
    i_in = 32'd0; leak = 32'd0; thr = 32'd0; v_reset = 32'd0; out_ready = 1'b0;
    test_reset();
    test_integrate();
    test_fire();
    test_refractory();
    test_equality_nan();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
